// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter: round-robin arbiter feeding one shared even-parity check
// stage. The granted word is captured, checked the next cycle, and the result is
// held under a valid/ready handshake.
// Optional feature macro: PARITY_ERR_CNT_EN adds a saturating error counter
// (err_cnt) with a synchronous clear (err_clr).
`timescale 1ns/1ps
module parity_check_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 2,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  input  logic [NREQ-1:0]    par,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDW-1:0]     res_id,
`ifdef PARITY_ERR_CNT_EN
  output logic               res_err,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               err_clr
`else
  output logic               res_err
`endif
);

  typedef enum logic [1:0] {StIdle, StCheck, StResult} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [DW:0]    word_q, word_d;
  logic [IDW-1:0] id_q, id_d;
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_err_q, res_err_d;

  logic           window;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           grant_fire;

  // Grant window: idle, or result being consumed this cycle.
  assign window     = (state_q == StIdle) || ((state_q == StResult) && res_ready);
  assign grant_fire = window && gnt_any;

  // Round-robin search: first pending request at or above ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDW'((32'(ptr_q) + off) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant is forced low while reset is asserted so held requests see no grant.
  always_comb begin
    gnt = '0;
    if (grant_fire && rst_n) begin
      gnt = NREQ'(1) << gnt_idx;
    end
  end

  // Next-state, capture and result registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    word_d      = word_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;

    if (grant_fire) begin
      word_d = {par[gnt_idx], data[gnt_idx*DW +: DW]};
      id_d   = gnt_idx;
      ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (grant_fire) state_d = StCheck;
      end
      StCheck: begin
        res_err_d   = ^word_q;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = StResult;
      end
      StResult: begin
        if (res_ready) begin
          // A consumed result never lingers into the next check cycle.
          res_valid_d = 1'b0;
          state_d     = grant_fire ? StCheck : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous reset discarding any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      word_q      <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      word_q      <= word_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of error results handed off; clear takes priority.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (res_valid_q && res_ready && res_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed testbench for parity_check_arbiter (NREQ=4, DW=2, CNT_W=2).
// Counter checks are compiled in when PARITY_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_parity_check_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] data;
  logic [3:0] par;
  logic [3:0] gnt;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_id;
  logic       res_err;
  logic       err_clr;
  logic [1:0] err_cnt;

  int errors = 0;
  int checks = 0;

`ifdef PARITY_ERR_CNT_EN
  parity_check_arbiter #(.NREQ(4), .DW(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .par(par), .gnt(gnt),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_err(res_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );
`else
  parity_check_arbiter #(.NREQ(4), .DW(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .par(par), .gnt(gnt),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_err(res_err)
  );
  assign err_cnt = 2'b00;
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reset pulse in the low phase; leaves inputs idle.
  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; data = '0; par = '0; res_ready = 1'b0; err_clr = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'b1111; data = '0; par = '0; res_ready = 1'b0; err_clr = 1'b0;
    #3;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d exp 0", res_id); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", res_err); end
`ifdef PARITY_ERR_CNT_EN
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", err_cnt); end
`endif
    req = '0;
  endtask

  task automatic test_single_good;
    apply_reset();
    req = 4'b0001; data = 8'b0000_0010; par = 4'b0001; res_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL good_gnt: got %b exp 0001", gnt); end
    @(negedge clk); req = 4'b0000; #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL good_check_gnt: got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin errors++;
      $display("FAIL good_check_state: busy=%b valid=%b exp busy=1 valid=0", busy, res_valid); end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b exp 1", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL good_id: got %0d exp 0", res_id); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL good_err: got %b exp 0", res_err); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL good_idle: busy=%b valid=%b exp 0 0", busy, res_valid); end
  endtask

  // Runs right after test_single_good: ptr is 1, counter 0.
  task automatic test_single_bad;
    @(negedge clk);
    req = 4'b0100; data = 8'b0011_0000; par = 4'b0100; res_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL bad_gnt: got %b exp 0100", gnt); end
    @(negedge clk); req = 4'b0000; #1;
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin errors++;
      $display("FAIL bad_result: valid=%b id=%0d exp 1 2", res_valid, res_id); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b exp 1", res_err); end
`ifdef PARITY_ERR_CNT_EN
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL bad_cnt_before: got %0d exp 0", err_cnt); end
`endif
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_idle: got %b exp 0", busy); end
`ifdef PARITY_ERR_CNT_EN
    checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL bad_cnt_after: got %0d exp 1", err_cnt); end
`endif
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_err_v;
    logic [3:0] exp_g;
    exp_err_v = 4'b0110;  // lane errors for data 11_01_10_00 with all par=0
    apply_reset();
    req = 4'b1111; data = 8'b11_01_10_00; par = 4'b0000; res_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rr_first_gnt: got %b exp 0001", gnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0000 || res_valid !== 1'b0) begin errors++;
        $display("FAIL rr_check_%0d: gnt=%b valid=%b exp 0000 0", i, gnt, res_valid); end
      @(negedge clk);
      if (i == 4) req = 4'b0000;
      #1;
      exp_g = (i == 4) ? 4'b0000 : (4'b0001 << ((i + 1) % 4));
      checks++; if (res_valid !== 1'b1 || res_id !== 2'(i % 4)) begin errors++;
        $display("FAIL rr_id_%0d: valid=%b id=%0d exp 1 %0d", i, res_valid, res_id, i % 4); end
      checks++; if (res_err !== exp_err_v[i % 4]) begin errors++;
        $display("FAIL rr_err_%0d: got %b exp %b", i, res_err, exp_err_v[i % 4]); end
      checks++; if (gnt !== exp_g) begin errors++;
        $display("FAIL rr_gnt_%0d: got %b exp %b", i, gnt, exp_g); end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    apply_reset();
    req = 4'b0011; data = '0; par = '0; res_ready = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt0: got %b exp 0001", gnt); end
    @(negedge clk); req = 4'b0010; #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || gnt !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b id=%0d gnt=%b busy=%b exp 1 0 0000 1",
                 i, res_valid, res_id, gnt, busy);
      end
    end
    @(negedge clk); res_ready = 1'b1; #1;
    checks++; if (gnt !== 4'b0010 || res_valid !== 1'b1) begin errors++;
      $display("FAIL bp_release: gnt=%b valid=%b exp 0010 1", gnt, res_valid); end
    @(negedge clk); req = 4'b0000; #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL bp_check: valid=%b busy=%b exp 0 1", res_valid, busy); end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin errors++;
      $display("FAIL bp_second: valid=%b id=%0d exp 1 1", res_valid, res_id); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b exp 0", busy); end
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic test_saturation;
    apply_reset();
    req = 4'b0001; data = 8'b0000_0011; par = 4'b0001; res_ready = 1'b1;
    #1;
    // Results appear in cycles 2,4,6,8,10,12 relative to this cycle.
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk); #1;
      if (c == 5) begin
        checks++; if (err_cnt !== 2'd2) begin errors++; $display("FAIL sat_mid: got %0d exp 2", err_cnt); end
      end
      if (c == 11) begin
        checks++; if (err_cnt !== 2'd3) begin errors++; $display("FAIL sat_stick: got %0d exp 3", err_cnt); end
      end
    end
    @(negedge clk); err_clr = 1'b1; req = 4'b0000; #1;
    checks++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin errors++;
      $display("FAIL sat_clr_hs: valid=%b err=%b exp 1 1", res_valid, res_err); end
    @(negedge clk); err_clr = 1'b0; #1;
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL sat_clear: got %0d exp 0", err_cnt); end
  endtask
`endif

  task automatic test_async_reset;
    apply_reset();
    req = 4'b0100; data = '0; par = '0; res_ready = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ar_gnt: got %b exp 0100", gnt); end
    @(negedge clk); req = 4'b0000;
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin errors++;
      $display("FAIL ar_result: valid=%b id=%0d exp 1 2", res_valid, res_id); end
    #1; rst_n = 1'b0; req = 4'b1010; #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL ar_immediate: valid=%b busy=%b exp 0 0", res_valid, busy); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ar_gnt_in_reset: got %b exp 0000", gnt); end
    #1; rst_n = 1'b1; #1;
    // ptr back at 0 picks lane 1 ahead of lane 3.
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ar_fresh_gnt: got %b exp 0010", gnt); end
    @(negedge clk); req = 4'b0000; #1;
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin errors++;
      $display("FAIL ar_fresh_result: valid=%b id=%0d exp 1 1", res_valid, res_id); end
    res_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_idle: got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_good();
    test_single_bad();
    test_round_robin();
    test_backpressure();
`ifdef PARITY_ERR_CNT_EN
    test_saturation();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_check_arbiter.md
# parity_check_arbiter

Shares one even-parity check stage among `NREQ` requesters, each presenting a `DW`-bit data word plus its parity bit. A round-robin arbiter grants one requester at a time and captures its word. The next cycle evaluates the word's even parity and registers a result tagged with the requester index. The result is held under a valid/ready handshake toward the downstream consumer. The block sits between the per-lane parity generators and the link status/error logic.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..16.
- `DW`, 2: data bits per requester; the checked word is `DW+1` bits (`{par, data}`).
- `CNT_W`, 8: error counter width (used only with `PARITY_ERR_CNT_EN`).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  request per requester; held high until granted.
- `data`  in  NREQ*DW  requester i data at `[i*DW +: DW]`.
- `par`  in  NREQ  requester i parity bit.
- `gnt`  out  NREQ  one-hot, combinational; high in the capture cycle only.
- `busy`  out  1  high when state is not IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_id`  out  max(1,$clog2(NREQ))  index of the checked requester.
- `res_err`  out  1  1 = odd number of ones in `{par,data}` (parity error).
- `err_cnt`  out  CNT_W  saturating error count (macro only).
- `err_clr`  in  1  synchronous counter clear (macro only).

## Operation
- FSM with three states: IDLE, CHECK and RESULT. Reset state is IDLE.
- **Grant window.** A grant may be issued when state is IDLE, or when state is RESULT with `res_ready`=1.
  - Within the window, `gnt[k]`=1 for the first k with `req[k]`=1, searching upward from `ptr` with wrap modulo NREQ.
  - If no request is pending, `gnt` is all zeros.
- **Capture.** On the edge where `gnt[k]`=1:
  - `word <= {par[k], data[k]}` and `id <= k`.
  - `ptr <= (k+1) mod NREQ`.
  - State goes to CHECK.
  - The requester may drop `req` or change its data after this edge.
- **CHECK.** Always lasts exactly one cycle, with no grant issued.
  - Registers `res_err <= ^word` and `res_id <= id`.
  - Sets `res_valid`=1 and goes to RESULT.
- **RESULT.** Outputs hold stable while `res_ready`=0.
  - On `res_ready`=1: go to CHECK if a grant is issued in the same cycle, otherwise go to IDLE and clear `res_valid`.
- `ptr` advances only on a grant and is 0 after reset.
- **Fairness.** With all requests held high, grants rotate 0,1,…,NREQ-1,0.
- `res_id` and `res_err` are don't-care while `res_valid`=0; they are driven 0 after reset.

## Timing
- Reset values: `gnt`=0, `busy`=0, `res_valid`=0, `res_id`=0, `res_err`=0, `err_cnt`=0, `ptr`=0.
- **Latency.** Grant in cycle N gives `res_valid`=1 from cycle N+2.
- **Throughput.** Peak rate is one result per 2 cycles, reached with `res_ready` tied to 1.
- **Backpressure.** While `res_valid`=1 and `res_ready`=0, no grant is issued and all requests wait.
- **Reset mid-operation.** Asserting `rst_n` low in CHECK or RESULT discards the captured word and result immediately (asynchronous). A requester whose request was already granted is not re-served unless it raises `req` again.
- `req` changing in a non-grant cycle has no effect.

## Configuration
- Macro: `PARITY_ERR_CNT_EN`.
- **Defined:** `err_cnt` and `err_clr` ports exist.
  - `err_cnt` increments by 1 on each result handshake (`res_valid & res_ready & res_err`).
  - It saturates at 2^CNT_W-1.
  - `err_clr`=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.
- **Undefined:** both ports and the counter are absent. All other behaviour is identical.

## Test plan
- **Single request, good parity.** `req`=0001, `data[0]`=2'b10, `par[0]`=1, `res_ready`=1 → `gnt`=0001 in cycle N; in cycle N+2 `res_valid`=1, `res_id`=0, `res_err`=0; IDLE in N+3.
- **Single request, bad parity.** `req`=0100, `data[2]`=2'b11, `par[2]`=1 → `res_id`=2, `res_err`=1; with the macro, `err_cnt` goes 0→1 after the handshake.
- **Round-robin.** `req`=1111 held, `res_ready`=1 → grant order 0,1,2,3,0 on every second cycle; the `res_id` sequence matches.
- **Backpressure.** `res_ready`=0 for 5 cycles with `req`=0011 → one result held stable and `gnt`=0 throughout; `gnt`=0010 in the cycle `res_ready` rises.
- **Saturation and clear** (macro, `CNT_W`=2). 5 error results → `err_cnt` sticks at 3; `err_clr` asserted with a concurrent error handshake → `err_cnt`=0.
- **Async reset in RESULT.** Pulse `rst_n` low mid-cycle → `res_valid`=0 and `busy`=0 immediately; after release, a held `req`=0010 is granted fresh with `ptr` at 0.
